// File: rtl/mem_port_pkg.sv
// Shared unit codes, bus width and strobe legality helper for the move-transfer core.
package mem_port_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned NUM_UNITS  = 16;

  // One-hot bit indices into the unit strobes
  localparam int unsigned UNIT_REG_NULL   = 0;
  localparam int unsigned UNIT_REG_PC     = 2;
  localparam int unsigned UNIT_REG_AR     = 3;
  localparam int unsigned UNIT_MEM_MEM_PC = 12;
  localparam int unsigned UNIT_MEM_MEM_AR = 13;
  localparam int unsigned UNIT_MEM_NULL   = 15;

  // Combinations this block refuses to act on.
  function automatic logic strobe_illegal(input logic [NUM_UNITS-1:0] ien,
                                          input logic [NUM_UNITS-1:0] oen);
    logic mem_src;
    logic mem_tgt;
    mem_src = oen[UNIT_MEM_MEM_PC] | oen[UNIT_MEM_MEM_AR];
    mem_tgt = ien[UNIT_MEM_MEM_PC] | ien[UNIT_MEM_MEM_AR];
    return ien[UNIT_MEM_MEM_PC]
         | (mem_src & mem_tgt)
         | (ien[UNIT_REG_PC] & ien[UNIT_REG_AR])
         | (oen[UNIT_REG_PC] & oen[UNIT_REG_AR])
         | (ien[UNIT_MEM_MEM_PC] & ien[UNIT_MEM_MEM_AR])
         | (oen[UNIT_MEM_MEM_PC] & oen[UNIT_MEM_MEM_AR]);
  endfunction

endpackage

// File: rtl/mem_port.sv
// Bus-side responder owning PC/AR; executes unit strobes against a req/ack memory
// and sources or sinks data on the core bus, stalling while an access is in flight.
module mem_port
  import mem_port_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_UNITS-1:0]  i_unit_ien,
  input  logic [NUM_UNITS-1:0]  i_unit_oen,
  input  logic [DATA_WIDTH-1:0] i_bus,
  output logic [DATA_WIDTH-1:0] o_bus,
  output logic                  o_bus_vld,
  output logic                  o_stall,
  output logic                  o_err,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRd, StRdDone, StWr} state_e;

  localparam logic [DATA_WIDTH-1:0] One = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ar_q, ar_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  tgt_pc_q, tgt_pc_d;
  logic                  tgt_ar_q, tgt_ar_d;
  logic                  fetch_q, fetch_d;
  logic                  err_q, err_d;
  logic                  illegal;
  logic                  mem_src;

  assign illegal = strobe_illegal(i_unit_ien, i_unit_oen);
  assign mem_src = i_unit_oen[UNIT_MEM_MEM_PC] | i_unit_oen[UNIT_MEM_MEM_AR];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ar_d     = ar_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    tgt_pc_d = tgt_pc_q;
    tgt_ar_d = tgt_ar_q;
    fetch_d  = fetch_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (illegal) begin
          err_d = 1'b1;
        end else if (mem_src) begin
          state_d  = StRd;
          addr_d   = i_unit_oen[UNIT_MEM_MEM_PC] ? pc_q : ar_q;
          fetch_d  = i_unit_oen[UNIT_MEM_MEM_PC];
          tgt_pc_d = i_unit_ien[UNIT_REG_PC];
          tgt_ar_d = i_unit_ien[UNIT_REG_AR];
        end else begin
          if (i_unit_ien[UNIT_REG_PC]) pc_d = i_bus;
          if (i_unit_ien[UNIT_REG_AR]) ar_d = i_bus;
          if (i_unit_ien[UNIT_MEM_MEM_AR]) begin
            state_d = StWr;
            addr_d  = ar_q;
            wdata_d = i_bus;
          end
        end
      end
      StRd: begin
        if (i_mem_ack) begin
          state_d = StRdDone;
          rdata_d = i_mem_rdata;
          if (fetch_q) pc_d = pc_q + One;
        end
      end
      StRdDone: begin
        // A PC target overrides the fetch increment applied at the ack edge
        if (tgt_pc_q) pc_d = rdata_q;
        if (tgt_ar_q) ar_d = rdata_q;
        tgt_pc_d = 1'b0;
        tgt_ar_d = 1'b0;
        state_d  = StIdle;
      end
      StWr: begin
        if (i_mem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      ar_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      tgt_pc_q <= 1'b0;
      tgt_ar_q <= 1'b0;
      fetch_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ar_q     <= ar_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      tgt_pc_q <= tgt_pc_d;
      tgt_ar_q <= tgt_ar_d;
      fetch_q  <= fetch_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    o_bus     = '0;
    o_bus_vld = 1'b0;
    if (state_q == StRdDone) begin
      o_bus     = rdata_q;
      o_bus_vld = 1'b1;
    end else if (state_q == StIdle && !illegal &&
                 (i_unit_oen[UNIT_REG_PC] || i_unit_oen[UNIT_REG_AR])) begin
      o_bus     = i_unit_oen[UNIT_REG_PC] ? pc_q : ar_q;
      o_bus_vld = 1'b1;
    end
  end

  assign o_stall     = (state_q != StIdle);
  assign o_err       = err_q;
  assign o_mem_req   = (state_q == StRd) || (state_q == StWr);
  assign o_mem_we    = (state_q == StWr);
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port.sv
// Scoreboard bench for mem_port: expected bus values queued at strobe time and
// compared whenever the block asserts o_bus_vld.
module tb_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ien, oen;
  logic [7:0]  bus_in;
  logic [7:0]  o_bus;
  logic        o_bus_vld, o_stall, o_err, o_mem_req, o_mem_we;
  logic [7:0]  o_mem_addr, o_mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  sb_q[$];

  always #5 clk = ~clk;

  mem_port u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_unit_ien  (ien),
    .i_unit_oen  (oen),
    .i_bus       (bus_in),
    .o_bus       (o_bus),
    .o_bus_vld   (o_bus_vld),
    .o_stall     (o_stall),
    .o_err       (o_err),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bit_of(input int idx);
    logic [15:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Bus monitor: every valid beat must match the oldest expectation.
  always @(negedge clk) begin
    if (o_bus_vld) begin
      if (sb_q.size() == 0) check_eq("bus_unexpected_vld", o_bus_vld, 1'b0);
      else check_eq("bus_data", o_bus, sb_q.pop_front());
    end else begin
      check_eq("bus_zero_when_idle", o_bus, 8'h00);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ie, input logic [15:0] oe, input logic [7:0] b);
    ien    = ie;
    oen    = oe;
    bus_in = b;
  endtask

  task automatic check_reset_outs();
    @(negedge clk);
    check_eq("rst_bus", o_bus, 8'h00);
    check_eq("rst_vld", o_bus_vld, 1'b0);
    check_eq("rst_stall", o_stall, 1'b0);
    check_eq("rst_err", o_err, 1'b0);
    check_eq("rst_req", o_mem_req, 1'b0);
    check_eq("rst_we", o_mem_we, 1'b0);
    check_eq("rst_addr", o_mem_addr, 8'h00);
    check_eq("rst_wdata", o_mem_wdata, 8'h00);
  endtask

  task automatic reg_write(input int idx, input logic [7:0] val);
    cyc();
    drive(bit_of(idx), 16'h0, val);
  endtask

  task automatic reg_read(input int idx, input logic [7:0] exp);
    cyc();
    drive(16'h0, bit_of(idx), 8'h00);
    sb_q.push_back(exp);
    @(negedge clk);
    check_eq("regrd_vld", o_bus_vld, 1'b1);
    check_eq("regrd_stall", o_stall, 1'b0);
  endtask

  // Serve one access already strobed this cycle; lat = req cycles including the ack cycle.
  task automatic mem_serve(input int lat, input logic [7:0] rd, input logic we,
                           input logic [7:0] addr, input logic [7:0] wd, input bit mid);
    for (int k = 0; k < lat; k++) begin
      cyc();
      if (mid && k > 0) drive(bit_of(2), bit_of(3), 8'h33);
      else drive(16'h0, 16'h0, 8'h00);
      mem_ack   = (k == lat - 1);
      mem_rdata = (k == lat - 1) ? rd : 8'h00;
      @(negedge clk);
      check_eq("acc_req", o_mem_req, 1'b1);
      check_eq("acc_we", o_mem_we, we);
      check_eq("acc_addr", o_mem_addr, addr);
      if (we) check_eq("acc_wdata", o_mem_wdata, wd);
      check_eq("acc_stall", o_stall, 1'b1);
    end
    cyc();
    drive(16'h0, 16'h0, 8'h00);
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    @(negedge clk);
    check_eq("after_ack_req", o_mem_req, 1'b0);
    check_eq("after_ack_stall", o_stall, !we);
  endtask

  task automatic err_case(input string tag, input logic [15:0] ie, input logic [15:0] oe);
    cyc();
    drive(ie, oe, 8'h11);
    cyc();
    drive(16'h0, 16'h0, 8'h00);
    @(negedge clk);
    check_eq({tag, "_err"}, o_err, 1'b1);
    check_eq({tag, "_req"}, o_mem_req, 1'b0);
    check_eq({tag, "_stall"}, o_stall, 1'b0);
    cyc();
    @(negedge clk);
    check_eq({tag, "_err_pulse"}, o_err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(16'h0, 16'h0, 8'h00);
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outs();

    // Register moves
    reg_write(3, 8'h5A);
    reg_read(3, 8'h5A);
    reg_write(2, 8'h10);
    reg_read(2, 8'h10);

    // Fetch through PC into AR, ack on the third req cycle
    cyc();
    drive(bit_of(3), bit_of(12), 8'h00);
    sb_q.push_back(8'h77);
    mem_serve(3, 8'h77, 1'b0, 8'h10, 8'h00, 1'b0);
    reg_read(2, 8'h11);
    reg_read(3, 8'h77);

    // Jump: PC target beats the wrapping increment
    reg_write(2, 8'hFF);
    cyc();
    drive(bit_of(2), bit_of(12), 8'h00);
    sb_q.push_back(8'h40);
    mem_serve(1, 8'h40, 1'b0, 8'hFF, 8'h00, 1'b0);
    reg_read(2, 8'h40);

    // Same fetch into AR: PC wraps to zero
    reg_write(2, 8'hFF);
    cyc();
    drive(bit_of(3), bit_of(12), 8'h00);
    sb_q.push_back(8'h41);
    mem_serve(1, 8'h41, 1'b0, 8'hFF, 8'h00, 1'b0);
    reg_read(2, 8'h00);
    reg_read(3, 8'h41);

    // Store via AR with strobes applied mid-access
    reg_write(3, 8'h20);
    cyc();
    drive(bit_of(13), 16'h0, 8'h9C);
    mem_serve(3, 8'h00, 1'b1, 8'h20, 8'h9C, 1'b1);
    reg_read(2, 8'h00);
    reg_read(3, 8'h20);

    // Illegal strobe combinations
    reg_write(2, 8'h5C);
    err_case("err_ien12", bit_of(12), 16'h0);
    err_case("err_memmem", bit_of(13), bit_of(13));
    err_case("err_oen23", bit_of(3), bit_of(2) | bit_of(3));
    reg_read(2, 8'h5C);
    reg_read(3, 8'h20);

    // Reset during a pending read, then a late ack
    cyc();
    drive(bit_of(3), bit_of(12), 8'h00);
    cyc();
    drive(16'h0, 16'h0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_req_before", o_mem_req, 1'b1);
    cyc();
    rst = 1'b0;
    check_reset_outs();
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 8'h99;
    @(negedge clk);
    check_eq("late_ack_vld", o_bus_vld, 1'b0);
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    @(negedge clk);
    check_eq("late_ack_vld_next", o_bus_vld, 1'b0);
    check_eq("late_ack_stall", o_stall, 1'b0);
    reg_read(2, 8'h00);
    reg_read(3, 8'h00);

    cyc();
    drive(16'h0, 16'h0, 8'h00);
    @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port.md
# mem_port

Bus-side responder for the move-transfer core: consumes the one-hot unit input/output strobes (bit order REG_NULL=0 … MEM_NULL=15) issued by the instruction decoder. It owns the PC and AR registers and serves the MEM_MEM_PC / MEM_MEM_AR units. It executes each strobe against an external req/ack memory and sources or sinks data on the core data bus, flagging stalls while an access is in flight.

## Interface
- DATA_WIDTH, 8, width of bus, PC, AR, memory data and address.
- clk  in  1  core clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_unit_ien  in  16  one-hot target strobe, this transfer's destination unit.
- i_unit_oen  in  16  one-hot source strobe, this transfer's source unit.
- i_bus  in  DATA_WIDTH  bus value from another source unit.
- o_bus  out  DATA_WIDTH  value sourced by this block.
- o_bus_vld  out  1  o_bus is valid this cycle.
- o_stall  out  1  access in flight, controller must hold further strobes.
- o_err  out  1  one-cycle pulse, illegal strobe combination.
- o_mem_req  out  1  memory request, held until ack.
- o_mem_we  out  1  1 = write, 0 = read, valid with req.
- o_mem_addr  out  DATA_WIDTH  access address, stable while req.
- o_mem_wdata  out  DATA_WIDTH  write data, stable while req.
- i_mem_ack  in  1  one-cycle completion, may arrive in the first req cycle.
- i_mem_rdata  in  DATA_WIDTH  read data, valid with ack.

## Operation
- States: IDLE, RD (req, we=0), RD_DONE (present data), WR (req, we=1).
- Strobes are sampled only in IDLE. Strobes in any other state are ignored with no error.
- In IDLE:
  - oen[2]/oen[3]: o_bus = PC/AR, o_bus_vld=1 in the same cycle (combinational), no state change.
  - ien[2]/ien[3] with a non-memory source: load PC/AR from i_bus at the edge.
- Read:
  - oen[12] or oen[13] → RD with addr = PC or AR, latched.
  - The pending target (ien[2] or ien[3] only) is latched.
  - On ack → RD_DONE: capture rdata.
  - RD_DONE: o_bus = captured data, o_bus_vld=1, latched PC/AR target loads at the edge, → IDLE.
- Fetch increment: a read sourced from oen[12] increments PC by 1 (mod 2^DATA_WIDTH, 0xFF→0x00) at the ack edge. A latched PC target load in RD_DONE overrides the increment: jump value wins.
- Write: ien[13] with a non-memory source → WR with addr = AR, wdata = i_bus, both latched. On ack → IDLE.
- Errors (o_err pulse, no other action, stay IDLE):
  - ien[12] (write via PC).
  - Memory source and memory target in the same transfer.
  - More than one bit set in bits [3:2] or [13:12] of either strobe.
- o_stall = (state != IDLE), registered.
- o_bus is 0 when o_bus_vld is 0.

## Timing
- Reset values: state IDLE, PC=0, AR=0, o_bus=0, o_bus_vld=0, o_stall=0, o_err=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
- Read cycle sequence:
  - Strobe at cycle N.
  - Req high from N+1 until the ack cycle A (A ≥ N+1).
  - o_bus_vld at A+1.
  - o_stall high N+1..A+1.
  - Minimum latency: 2 cycles.
- Write: req high N+1..A, o_stall high N+1..A, back to IDLE at A+1.
- Req drops at the edge after ack; no back-to-back requests without an IDLE cycle.
- Ack while in IDLE or RD_DONE is ignored.
- Reset mid-access: rst wins at the next edge. Req drops, the pending target is discarded, and a late ack is ignored.

## Structure
- Unit codes (REG_NULL…MEM_NULL), one-hot bit indices, and DATA_WIDTH belong in the shared define.v. Code against those names only.
- State encoding is local to this block.
- Single module; PC/AR are small enough that no sub-module is warranted.

## Test plan
- Register moves: rst, ien[3] with i_bus=0x5A → AR=0x5A; next cycle oen[3] → o_bus=0x5A, o_bus_vld=1 same cycle, o_stall=0.
- Fetch increment: PC=0x10, oen[12]+ien[3], ack 3 cycles after req with rdata=0x77:
  - req/addr=0x10 held 3 cycles.
  - o_bus=0x77, vld at ack+1.
  - AR=0x77, PC=0x11.
- Jump: PC=0xFF, oen[12]+ien[2], rdata=0x40, ack in the first req cycle → vld 2 cycles after strobe, PC=0x40 (not 0x00). Repeat with ien[3] → PC wraps to 0x00.
- Store: AR=0x20, i_bus=0x9C, ien[13] → req=1, we=1, addr=0x20, wdata=0x9C until ack; o_stall drops cycle after ack. Strobes applied mid-access have no effect.
- Errors: ien[12]; oen[13]+ien[13]; oen bits 2 and 3 both set → one-cycle o_err each; no req; PC/AR unchanged.
- Reset mid-read: assert rst while req pending → req=0 and all outputs at reset values next cycle; ack one cycle later → no vld, PC=0.
